// File: rtl/rr_arbiter8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types and sizing constants for the rr_arbiter8 slice.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

   localparam int N_REQ  = 8;   // number of requesters
   localparam int IDX_W  = 3;   // width of a requester index
   localparam int HOLD_W = 8;   // width of the hold-time counter (MAX_HOLD <= 255)

   // Arbiter state encoding, kept as plain 1-bit constants for legacy tools
   typedef logic [0:0] state_t;
   localparam state_t IDLE  = 1'b0;
   localparam state_t GRANT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter8_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8_if
// Brief    : Request/grant bundle between requesters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_arbiter8_if;
   import arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   // Requester side
   modport master (
      output req, done,
      input  gnt, gnt_idx, gnt_valid, timeout
   );

   // Arbiter side
   modport slave (
      input  req, done,
      output gnt, gnt_idx, gnt_valid, timeout
   );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter8_onehot_dec3.sv
`default_nettype none
// ============================================================================
// Module   : onehot_dec3
// Brief    : 3-to-8 one-hot decoder with enable, purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_dec3
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic             en,
   output logic [N_REQ-1:0] onehot
);

   // Decode the index; all zero when disabled
   always_comb begin
      onehot = '0;
      if (en) begin
         onehot = N_REQ'(1) << idx;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Brief    : Eight-way round-robin arbiter with hold-time limit. Grants are
//            held until done, owner withdrawal, or MAX_HOLD cycles elapse.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
)(
   input  logic            clk,
   input  logic            rst,
   rr_arbiter8_if.slave    bus
);

   localparam logic [HOLD_W-1:0] c_MAX_HOLD = HOLD_W'(MAX_HOLD);

   state_t            r_state,   w_state_nxt;
   logic [IDX_W-1:0]  r_ptr,     w_ptr_nxt;
   logic [IDX_W-1:0]  r_gnt_idx, w_idx_nxt;
   logic              r_valid,   w_valid_nxt;
   logic [HOLD_W-1:0] r_hold,    w_hold_nxt;
   logic              r_timeout, w_timeout_nxt;
   logic [N_REQ-1:0]  r_gnt,     w_gnt_dec;
   logic [IDX_W-1:0]  w_pick;

   // Rotate requests so ptr sits at bit 0, take the lowest set bit, then
   // add ptr back; the 3-bit add wraps naturally modulo 8.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [N_REQ-1:0] rot;
      logic [IDX_W-1:0] off;
      rot = N_REQ'({req, req} >> ptr);
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = IDX_W'(i);
      end
      return ptr + off;
   endfunction

   assign w_pick = rr_pick(bus.req, r_ptr);

   // Next-state logic: search in IDLE, release/hold/force-release in GRANT
   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_idx_nxt     = r_gnt_idx;
      w_valid_nxt   = r_valid;
      w_hold_nxt    = r_hold;
      w_timeout_nxt = 1'b0;
      if (r_state == IDLE) begin
         if (bus.req != '0) begin
            w_state_nxt = GRANT;
            w_idx_nxt   = w_pick;
            w_valid_nxt = 1'b1;
            w_hold_nxt  = HOLD_W'(1);
         end
      end else begin
         // done has priority over the hold limit, so a collision is a
         // normal release without a timeout pulse
         if (bus.done || !bus.req[r_gnt_idx] || (r_hold == c_MAX_HOLD)) begin
            w_state_nxt   = IDLE;
            w_idx_nxt     = '0;
            w_valid_nxt   = 1'b0;
            w_hold_nxt    = '0;
            w_ptr_nxt     = r_gnt_idx + IDX_W'(1);
            w_timeout_nxt = !bus.done && bus.req[r_gnt_idx];
         end else begin
            w_hold_nxt = r_hold + HOLD_W'(1);
         end
      end
   end

   // The one-hot grant is decoded from next-state index so gnt stays registered
   onehot_dec3 u_dec (
      .idx    (w_idx_nxt),
      .en     (w_valid_nxt),
      .onehot (w_gnt_dec)
   );

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_gnt_idx <= '0;
         r_valid   <= 1'b0;
         r_hold    <= '0;
         r_timeout <= 1'b0;
         r_gnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_gnt_idx <= w_idx_nxt;
         r_valid   <= w_valid_nxt;
         r_hold    <= w_hold_nxt;
         r_timeout <= w_timeout_nxt;
         r_gnt     <= w_gnt_dec;
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_idx   = r_gnt_idx;
   assign bus.gnt_valid = r_valid;
   assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire
